vec_mem_sequencer: RTL and testbench

//   Sits between the cpu memory port and a single-port 32-bit data RAM.

---
 rtl/vec_mem_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_vec_mem_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_mem_sequencer.sv
// vec_mem_sequencer
// Turns one cpu memory op (a scalar word or a LANES-wide vector) into a run of
// single-word accesses on a single-port RAM, one per cycle. The cpu is stalled
// until the op finishes. Loads return all gathered lanes in a single beat.
module vec_mem_sequencer #(
  parameter int LANES  = 16,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 18,
  parameter int RD_LAT = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_req_valid,
  input  logic                    i_req_write,
  input  logic                    i_req_vec,
  input  logic [ADDR_W-1:0]       i_req_addr,
  input  logic [LANES*DATA_W-1:0] i_req_wdata,
  output logic                    o_req_ready,
  output logic                    o_stall,
  output logic                    o_resp_valid,
  output logic [LANES*DATA_W-1:0] o_resp_rdata,
  output logic [ADDR_W-1:0]       o_mem_addr,
  output logic [DATA_W-1:0]       o_mem_wdata,
  output logic                    o_mem_we,
  input  logic [DATA_W-1:0]       i_mem_rdata
);

  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int LAT_W = 3;
  localparam logic [CNT_W-1:0] LAST_VEC   = CNT_W'(LANES - 1);
  localparam logic [LAT_W-1:0] DRAIN_LAST = LAT_W'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              r_state;
  logic                r_vec;
  logic [CNT_W-1:0]    r_issue_cnt;
  logic [LAT_W-1:0]    r_drain_cnt;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_mem_we;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_wlane [LANES];
  logic [DATA_W-1:0]   r_rlane [LANES];
  logic [CNT_W-1:0]    r_cap_cnt;
  logic [RD_LAT-1:0]   r_cap_pipe;

  logic                w_accept;
  logic                w_load_accept;
  logic                w_issue;
  logic [CNT_W-1:0]    w_last_beat;
  logic [CNT_W-1:0]    w_next_beat;

  assign w_accept      = (r_state == S_IDLE) && i_req_valid;
  assign w_load_accept = w_accept && !i_req_write;
  assign w_issue       = (r_state == S_READ);
  assign w_last_beat   = r_vec ? LAST_VEC : '0;
  assign w_next_beat   = r_issue_cnt + CNT_W'(1);

  // Sequencer FSM: drives the RAM port from registers, one word per beat.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_vec        <= 1'b0;
      r_issue_cnt  <= '0;
      r_drain_cnt  <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_we     <= 1'b0;
      r_resp_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_resp_valid <= 1'b0;
          if (i_req_valid) begin
            r_vec       <= i_req_vec;
            r_issue_cnt <= '0;
            r_drain_cnt <= '0;
            r_mem_addr  <= i_req_addr;
            r_mem_we    <= i_req_write;
            r_mem_wdata <= i_req_write ? i_req_wdata[DATA_W-1:0] : '0;
            r_state     <= i_req_write ? S_WRITE : S_READ;
          end
        end
        S_WRITE: begin
          if (r_issue_cnt == w_last_beat) begin
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_we     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_issue_cnt <= w_next_beat;
            r_mem_addr  <= r_mem_addr + ADDR_W'(1);
            r_mem_wdata <= r_wlane[w_next_beat];
          end
        end
        S_READ: begin
          if (r_issue_cnt == w_last_beat) begin
            r_mem_addr  <= '0;
            r_drain_cnt <= '0;
            r_state     <= S_DRAIN;
          end else begin
            r_issue_cnt <= w_next_beat;
            r_mem_addr  <= r_mem_addr + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt == DRAIN_LAST) begin
            r_resp_valid <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_drain_cnt <= r_drain_cnt + LAT_W'(1);
          end
        end
        S_DONE: begin
          r_resp_valid <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          r_mem_addr   <= '0;
          r_mem_wdata  <= '0;
          r_mem_we     <= 1'b0;
          r_resp_valid <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  // Snapshot the store data on accept so later cpu changes cannot leak in.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      for (int l = 0; l < LANES; l++) begin
        r_wlane[l] <= i_req_wdata[l*DATA_W +: DATA_W];
      end
    end
  end

  // Load capture: a delay line tracks each issued read so its data lands in the right lane.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cap_pipe <= '0;
      r_cap_cnt  <= '0;
      for (int l = 0; l < LANES; l++) begin
        r_rlane[l] <= '0;
      end
    end else begin
      r_cap_pipe[0] <= w_issue;
      for (int k = 1; k < RD_LAT; k++) begin
        r_cap_pipe[k] <= r_cap_pipe[k-1];
      end
      if (w_load_accept) begin
        r_cap_cnt <= '0;
        for (int l = 0; l < LANES; l++) begin
          r_rlane[l] <= '0;
        end
      end else if (r_cap_pipe[RD_LAT-1]) begin
        r_rlane[r_cap_cnt] <= i_mem_rdata;
        r_cap_cnt          <= r_cap_cnt + CNT_W'(1);
      end
    end
  end

  // Flatten the gathered lanes onto the response bus.
  always_comb begin
    o_resp_rdata = '0;
    for (int l = 0; l < LANES; l++) begin
      o_resp_rdata[l*DATA_W +: DATA_W] = r_rlane[l];
    end
  end

  assign o_req_ready  = (r_state == S_IDLE);
  assign o_stall      = w_accept || (r_state == S_WRITE) || (r_state == S_READ) ||
                        (r_state == S_DRAIN);
  assign o_resp_valid = r_resp_valid;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_mem_we     = r_mem_we;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// tb_vec_mem_sequencer
// Two sequencers (RAM read latency 1 and 3) each sit on a behavioural RAM.
// Stimulus pushes the expected RAM writes and responses into queues; a monitor
// on the falling edge pops and compares whenever the selected DUT acts.
module tb_vec_mem_sequencer;

  localparam int LANES  = 16;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 18;
  localparam int VW     = LANES * DATA_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct packed {
    logic [VW-1:0] rdata;
    logic [31:0]   lat;
  } rsp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              sel;
  logic              reqValid;
  logic              reqWrite;
  logic              reqVec;
  logic [ADDR_W-1:0] reqAddr;
  logic [VW-1:0]     reqWdata;

  logic              valid0, valid1;
  logic              ready0, ready1, stall0, stall1, rv0, rv1, mwe0, mwe1;
  logic [VW-1:0]     rdata0, rdata1;
  logic [ADDR_W-1:0] maddr0, maddr1;
  logic [DATA_W-1:0] mwd0, mwd1, mrd0, mrd1;

  logic              readyM, stallM, rvM, mweM;
  logic [VW-1:0]     rdataM;
  logic [ADDR_W-1:0] maddrM;
  logic [DATA_W-1:0] mwdM;

  bit   [DATA_W-1:0] mem0 [0:(1<<ADDR_W)-1];
  bit   [DATA_W-1:0] mem1 [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] p0, p1a, p1b, p1c;

  wr_t  wq[$];
  rsp_t rq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   wrMonEn = 1'b1;
  int   accCyc = 0;
  int   stallCnt = 0;
  wr_t  monW;
  rsp_t monR;

  always #5 clk = ~clk;

  assign valid0 = reqValid & ~sel;
  assign valid1 = reqValid & sel;

  vec_mem_sequencer #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(1)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(valid0), .i_req_write(reqWrite),
    .i_req_vec(reqVec), .i_req_addr(reqAddr), .i_req_wdata(reqWdata),
    .o_req_ready(ready0), .o_stall(stall0), .o_resp_valid(rv0), .o_resp_rdata(rdata0),
    .o_mem_addr(maddr0), .o_mem_wdata(mwd0), .o_mem_we(mwe0), .i_mem_rdata(mrd0)
  );

  vec_mem_sequencer #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(3)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(valid1), .i_req_write(reqWrite),
    .i_req_vec(reqVec), .i_req_addr(reqAddr), .i_req_wdata(reqWdata),
    .o_req_ready(ready1), .o_stall(stall1), .o_resp_valid(rv1), .o_resp_rdata(rdata1),
    .o_mem_addr(maddr1), .o_mem_wdata(mwd1), .o_mem_we(mwe1), .i_mem_rdata(mrd1)
  );

  assign readyM = sel ? ready1 : ready0;
  assign stallM = sel ? stall1 : stall0;
  assign rvM    = sel ? rv1    : rv0;
  assign mweM   = sel ? mwe1   : mwe0;
  assign rdataM = sel ? rdata1 : rdata0;
  assign maddrM = sel ? maddr1 : maddr0;
  assign mwdM   = sel ? mwd1   : mwd0;

  // RAM behind the latency-1 sequencer
  always @(posedge clk) begin
    if (mwe0) mem0[maddr0] <= mwd0;
    p0 <= mem0[maddr0];
  end
  assign mrd0 = p0;

  // RAM behind the latency-3 sequencer
  always @(posedge clk) begin
    if (mwe1) mem1[maddr1] <= mwd1;
    p1a <= mem1[maddr1];
    p1b <= p1a;
    p1c <= p1b;
  end
  assign mrd1 = p1c;

  // Cycle counter used to time accept-to-response latency
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] vecData(input logic [31:0] base, input logic [31:0] step);
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*DATA_W +: DATA_W] = base + step * 32'(i);
    return v;
  endfunction

  task automatic pushWrites(input logic [ADDR_W-1:0] a, input logic [VW-1:0] d, input bit v);
    wr_t e;
    int n;
    n = v ? LANES : 1;
    for (int i = 0; i < n; i++) begin
      e.addr = a + ADDR_W'(i);
      e.data = d[i*DATA_W +: DATA_W];
      wq.push_back(e);
    end
  endtask

  task automatic pushResp(input logic [VW-1:0] d, input int lat);
    rsp_t r;
    r.rdata = d;
    r.lat   = 32'(lat);
    rq.push_back(r);
  endtask

  // Present an op, hold it (optionally corrupted) while stalled, release after resp_valid
  task automatic applyStimulus(input bit s, input bit w, input bit v, input logic [ADDR_W-1:0] a,
                               input logic [VW-1:0] d, input bit scramble);
    bit acc;
    bit done;
    int n;
    sel = s; reqWrite = w; reqVec = v; reqAddr = a; reqWdata = d; reqValid = 1'b1;
    acc = 1'b0; n = 0;
    while (!acc && n < 50) begin
      @(negedge clk); acc = readyM;
      @(posedge clk); #1; n++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("[TB] FAIL accept_timeout actual=no_accept required=accept");
    end
    if (scramble) begin
      reqAddr = ~a; reqWdata = ~d; reqWrite = ~w; reqVec = ~v;
    end
    done = 1'b0; n = 0;
    while (!done && n < 60) begin
      @(negedge clk); done = rvM;
      @(posedge clk); #1; n++;
    end
    if (!done) begin
      checks++; errors++;
      $display("[TB] FAIL resp_timeout actual=no_resp required=resp");
    end
    reqValid = 1'b0;
    checkOutput("idle_ready", VW'(readyM), VW'(1));
    checkOutput("idle_mem_outputs", VW'({mweM, maddrM, mwdM}), '0);
  endtask

  // Scoreboard monitor: compares RAM writes and responses as the DUT produces them
  always @(negedge clk) begin
    if (!rst) begin
      if (mweM && wrMonEn) begin
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_write actual=%0h required=none", maddrM);
        end else begin
          monW = wq.pop_front();
          checkOutput("wr_addr", VW'(maddrM), VW'(monW.addr));
          checkOutput("wr_data", VW'(mwdM), VW'(monW.data));
        end
      end
      if (reqValid && readyM) begin
        accCyc   = cyc;
        stallCnt = 0;
      end
      if (stallM) stallCnt++;
      if (rvM) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_resp actual=resp_valid required=none");
        end else begin
          monR = rq.pop_front();
          checkOutput("resp_rdata", rdataM, monR.rdata);
          checkOutput("resp_latency", VW'(cyc - accCyc), VW'(monR.lat));
          checkOutput("stall_cycles", VW'(stallCnt), VW'(monR.lat));
          checkOutput("stall_at_resp", VW'(stallM), '0);
        end
      end
    end
  end

  // Directed test sequence
  initial begin
    logic [VW-1:0] dA, dB, dC, dD, dS;
    bit acc;
    int n;
    rst = 1'b1; sel = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqVec = 1'b0;
    reqAddr = '0; reqWdata = '0;
    dA = vecData(32'hA000, 32'h1);
    dB = vecData(32'hB000, 32'h1);
    dC = vecData(32'hC000, 32'h11);
    dD = vecData(32'hD000, 32'h1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    checkOutput("rst_ready0", VW'(ready0), VW'(1));
    checkOutput("rst_ready1", VW'(ready1), VW'(1));
    checkOutput("rst_ctrl0", VW'({stall0, rv0, mwe0, maddr0, mwd0}), '0);
    checkOutput("rst_ctrl1", VW'({stall1, rv1, mwe1, maddr1, mwd1}), '0);
    checkOutput("rst_rdata0", rdata0, '0);
    checkOutput("rst_rdata1", rdata1, '0);

    $display("[TB] vector store 0x100");
    pushWrites(18'h00100, dA, 1'b1); pushResp('0, 17);
    applyStimulus(1'b0, 1'b1, 1'b1, 18'h00100, dA, 1'b0);

    $display("[TB] vector load 0x100");
    pushResp(dA, 18);
    applyStimulus(1'b0, 1'b0, 1'b1, 18'h00100, '0, 1'b1);

    $display("[TB] scalar store/load 0x3FFFF");
    dS = {dA[VW-1:DATA_W], 32'h12345678};
    pushWrites(18'h3FFFF, dS, 1'b0); pushResp(dA, 2);
    applyStimulus(1'b0, 1'b1, 1'b0, 18'h3FFFF, dS, 1'b0);
    pushResp(VW'(32'h12345678), 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 18'h3FFFF, '0, 1'b0);

    $display("[TB] wrapping vector store/load 0x3FFF8");
    pushWrites(18'h3FFF8, dB, 1'b1); pushResp(VW'(32'h12345678), 17);
    applyStimulus(1'b0, 1'b1, 1'b1, 18'h3FFF8, dB, 1'b1);
    pushResp(dB, 18);
    applyStimulus(1'b0, 1'b0, 1'b1, 18'h3FFF8, '0, 1'b0);

    $display("[TB] back-to-back store/load, latency 1");
    pushWrites(18'h02000, dC, 1'b1); pushResp(dB, 17);
    applyStimulus(1'b0, 1'b1, 1'b1, 18'h02000, dC, 1'b1);
    pushResp(dC, 18);
    applyStimulus(1'b0, 1'b0, 1'b1, 18'h02000, '0, 1'b1);

    $display("[TB] back-to-back store/load, latency 3");
    pushWrites(18'h00300, dD, 1'b1); pushResp('0, 17);
    applyStimulus(1'b1, 1'b1, 1'b1, 18'h00300, dD, 1'b1);
    pushResp(dD, 20);
    applyStimulus(1'b1, 1'b0, 1'b1, 18'h00300, '0, 1'b1);
    pushResp(VW'(32'hD005), 5);
    applyStimulus(1'b1, 1'b0, 1'b0, 18'h00305, '0, 1'b0);

    $display("[TB] reset during vector store");
    wrMonEn = 1'b0;
    sel = 1'b0; reqWrite = 1'b1; reqVec = 1'b1; reqAddr = 18'h00200; reqWdata = dA;
    reqValid = 1'b1;
    acc = 1'b0; n = 0;
    while (!acc && n < 50) begin
      @(negedge clk); acc = ready0;
      @(posedge clk); #1; n++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("[TB] FAIL accept_timeout actual=no_accept required=accept");
    end
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("pre_rst_we", VW'(mwe0), VW'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_mid_we", VW'({mwe0, rv0}), '0);
    @(posedge clk); #1;
    checkOutput("rst_mid_we2", VW'({mwe0, rv0}), '0);
    rst = 1'b0; reqValid = 1'b0;
    checkOutput("post_rst_ready", VW'(ready0), VW'(1));
    checkOutput("post_rst_rdata", rdata0, '0);
    repeat (25) @(posedge clk);
    #1 wrMonEn = 1'b1;

    $display("[TB] scalar load after reset");
    pushResp(VW'(32'hA000), 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 18'h00100, '0, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    checkOutput("writes_left", VW'(wq.size()), '0);
    checkOutput("resps_left", VW'(rq.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so a stuck DUT cannot hang the run
  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
